usb_tx_bit_scheduler: RTL and testbench



---
 rtl/usb_tx_bit_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_usb_tx_bit_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_bit_scheduler.sv
// USB transmit bit scheduler: bit-period timing, sync/data/EOP sequencing,
// byte prefetch from the TX packet buffer and underrun abort.
module usb_tx_bit_scheduler #(
  parameter int unsigned CLKS_PER_BIT  = 8,
  parameter int unsigned PREFETCH_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [6:0] byte_count,
  input  logic       stuff_stall,
  input  logic       byte_valid,
  output logic       byte_req,
  output logic       load_sync,
  output logic       load_byte,
  output logic       shift_strobe,
  output logic       eop_active,
  output logic       tx_done,
  output logic       busy,
  output logic       underrun_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] PF_BIT = 3'(8 - PREFETCH_BITS);
  localparam logic [2:0] EOP_LAST = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_EOP   = 3'd3,
    ST_ABORT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       bytes_left_q, bytes_left_d;
  logic             req_pend_q, req_pend_d;
  logic             byte_ready_q, byte_ready_d;
  logic             byte_req_q, byte_req_d;
  logic             load_sync_q, load_sync_d;
  logic             load_byte_q, load_byte_d;
  logic             shift_strobe_q, shift_strobe_d;
  logic             eop_active_q, eop_active_d;
  logic             tx_done_q, tx_done_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;
  logic [2:0]       bit_nxt;
  logic             have_byte;

  // Next-state, counters and registered strobes
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    bytes_left_d   = bytes_left_q;
    req_pend_d     = req_pend_q;
    byte_ready_d   = byte_ready_q;
    underrun_d     = underrun_q;
    byte_req_d     = 1'b0;
    load_sync_d    = 1'b0;
    load_byte_d    = 1'b0;
    tx_done_d      = 1'b0;
    bit_nxt        = bit_cnt_q + 3'd1;
    have_byte      = byte_ready_q || (req_pend_q && byte_valid);
    if (state_q == ST_IDLE || clk_cnt_q == CNT_MAX) begin
      clk_cnt_d = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SYNC;
          load_sync_d  = 1'b1;
          bytes_left_d = byte_count;
          underrun_d   = 1'b0;
          bit_cnt_d    = 3'd0;
          req_pend_d   = 1'b0;
          byte_ready_d = 1'b0;
        end
      end

      ST_SYNC, ST_DATA: begin
        if (req_pend_q && byte_valid) begin
          byte_ready_d = 1'b1;
          req_pend_d   = 1'b0;
        end
        // A stalled strobe repeats the current bit position
        if (shift_strobe_q && !stuff_stall) begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            if (bytes_left_q == 7'd0) begin
              state_d   = ST_EOP;
              clk_cnt_d = '0;
            end else if (have_byte) begin
              state_d      = ST_DATA;
              load_byte_d  = 1'b1;
              bytes_left_d = bytes_left_q - 7'd1;
              byte_ready_d = 1'b0;
              req_pend_d   = 1'b0;
            end else begin
              state_d    = ST_ABORT;
              underrun_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_nxt;
            if (bit_nxt == PF_BIT && bytes_left_q != 7'd0 && !req_pend_q) begin
              byte_req_d = 1'b1;
              req_pend_d = 1'b1;
            end
          end
        end
      end

      ST_ABORT: begin
        state_d      = ST_EOP;
        clk_cnt_d    = '0;
        bit_cnt_d    = 3'd0;
        req_pend_d   = 1'b0;
        byte_ready_d = 1'b0;
      end

      ST_EOP: begin
        // bit_cnt counts the three EOP bit periods; stuffing does not apply
        if (shift_strobe_q) begin
          if (bit_cnt_q == EOP_LAST) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            tx_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_nxt;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    shift_strobe_d = (state_d == ST_SYNC || state_d == ST_DATA || state_d == ST_EOP) &&
                     (clk_cnt_d == CNT_MAX);
    eop_active_d   = (state_d == ST_EOP);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q        <= ST_IDLE;
      clk_cnt_q      <= '0;
      bit_cnt_q      <= 3'd0;
      bytes_left_q   <= 7'd0;
      req_pend_q     <= 1'b0;
      byte_ready_q   <= 1'b0;
      byte_req_q     <= 1'b0;
      load_sync_q    <= 1'b0;
      load_byte_q    <= 1'b0;
      shift_strobe_q <= 1'b0;
      eop_active_q   <= 1'b0;
      tx_done_q      <= 1'b0;
      busy_q         <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      clk_cnt_q      <= clk_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      bytes_left_q   <= bytes_left_d;
      req_pend_q     <= req_pend_d;
      byte_ready_q   <= byte_ready_d;
      byte_req_q     <= byte_req_d;
      load_sync_q    <= load_sync_d;
      load_byte_q    <= load_byte_d;
      shift_strobe_q <= shift_strobe_d;
      eop_active_q   <= eop_active_d;
      tx_done_q      <= tx_done_d;
      busy_q         <= busy_d;
      underrun_q     <= underrun_d;
    end
  end

  assign byte_req     = byte_req_q;
  assign load_sync    = load_sync_q;
  assign load_byte    = load_byte_q;
  assign shift_strobe = shift_strobe_q;
  assign eop_active   = eop_active_q;
  assign tx_done      = tx_done_q;
  assign busy         = busy_q;
  assign underrun_err = underrun_q;

endmodule

// File: tb/tb_usb_tx_bit_scheduler.sv
// Bench for usb_tx_bit_scheduler: per-cycle vector table built from a
// bit-period-level packet model, plus fixed-latency checks on directed packets.
module tb_usb_tx_bit_scheduler;

  localparam int unsigned CPB  = 8;
  localparam int unsigned PF   = 2;
  localparam int          MAXC = 32768;
  localparam int B_REQ = 0, B_LS = 1, B_LB = 2, B_SS = 3;
  localparam int B_EOP = 4, B_DONE = 5, B_BUSY = 6, B_UR = 7;

  typedef struct packed {
    logic       n_rst;
    logic       start;
    logic [6:0] bc;
    logic       stall;
    logic       valid;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] byte_count = 7'd0;
  logic       stuff_stall = 1'b0;
  logic       byte_valid = 1'b0;
  logic       byte_req, load_sync, load_byte, shift_strobe;
  logic       eop_active, tx_done, busy, underrun_err;

  vec_t       vecs [MAXC];
  logic [7:0] act  [MAXC];
  int         fill_pos;
  bit         ur_cur;
  int         n_vec;
  int         n_bad;

  usb_tx_bit_scheduler #(.CLKS_PER_BIT(CPB), .PREFETCH_BITS(PF)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .byte_count(byte_count),
    .stuff_stall(stuff_stall), .byte_valid(byte_valid), .byte_req(byte_req),
    .load_sync(load_sync), .load_byte(load_byte), .shift_strobe(shift_strobe),
    .eop_active(eop_active), .tx_done(tx_done), .busy(busy),
    .underrun_err(underrun_err)
  );

  always #5 clk = ~clk;

  task automatic set_ev(input int c, input int b);
    vecs[c].exp[b] = 1'b1;
  endtask

  // Idle cycles: only the sticky error shows; stray byte_valid must be ignored
  task automatic idle_until(input int c);
    for (int k = fill_pos; k < c; k++) begin
      vecs[k].exp[B_UR] = ur_cur;
      if ($urandom_range(0, 9) == 0) vecs[k].valid = 1'b1;
    end
    fill_pos = c;
  endtask

  // Packet model: walks bit periods, p = unstalled bits sent in current byte,
  // b = bytes loaded so far (0 while sending sync).
  task automatic build_packet(input int s, input int n, input int stall_pct,
                              input int fix_bit, input int withhold,
                              input int vdelay, input bit noise,
                              output int t0, output int e_end);
    int b, p, j, tt, e, t_ur, valid_t;
    bit fixed_done, st;
    idle_until(s);
    vecs[s].start = 1'b1;
    vecs[s].bc = 7'(n);
    vecs[s].exp[B_UR] = ur_cur;
    t0 = s + 1;
    b = 0; p = 0; j = 0; e = 0; t_ur = -1; valid_t = MAXC; fixed_done = 1'b0;
    set_ev(t0, B_LS);
    while (e == 0) begin
      tt = t0 + int'(CPB) * j + int'(CPB) - 1;
      set_ev(tt, B_SS);
      st = 1'b0;
      if (fix_bit >= 0 && !fixed_done && b == 0 && p == fix_bit) begin
        st = 1'b1;
        fixed_done = 1'b1;
      end else if ($urandom_range(0, 99) < stall_pct) begin
        st = 1'b1;
      end
      vecs[tt].stall = st;
      if (noise && $urandom_range(0, 3) == 0) vecs[tt - 4].stall = 1'b1;
      if (!st) begin
        p++;
        if (p == 8 - int'(PF) && b < n) begin
          set_ev(tt + 1, B_REQ);
          if (b + 1 != withhold) begin
            valid_t = tt + 1 + vdelay;
            vecs[valid_t].valid = 1'b1;
          end
        end
        if (p == 8) begin
          if (b == n) begin
            e = tt + 1;
          end else if (valid_t <= tt) begin
            set_ev(tt + 1, B_LB);
            b++;
            p = 0;
            valid_t = MAXC;
            if (noise) vecs[tt + 3].valid = 1'b1;
          end else begin
            t_ur = tt + 1;
            e = tt + 2;
            vecs[tt + 1].valid = 1'b1;
            vecs[tt + 3].valid = 1'b1;
          end
        end
      end
      j++;
    end
    for (int k = 0; k < 3; k++) begin
      tt = e + int'(CPB) * k + int'(CPB) - 1;
      set_ev(tt, B_SS);
      if (noise && $urandom_range(0, 1) == 0) vecs[tt].stall = 1'b1;
    end
    e_end = e + 3 * int'(CPB);
    for (int c = t0; c < e_end; c++) begin
      set_ev(c, B_BUSY);
      if (c >= e) set_ev(c, B_EOP);
    end
    set_ev(e_end, B_DONE);
    if (t_ur >= 0) begin
      for (int c = t_ur; c <= e_end; c++) set_ev(c, B_UR);
    end
    ur_cur = (t_ur >= 0);
    if (noise) begin
      for (int k = 0; k < 2; k++) begin
        tt = int'($urandom_range(t0 + 1, e_end - 1));
        vecs[tt].start = 1'b1;
        vecs[tt].bc = 7'($urandom_range(0, 64));
      end
    end
    fill_pos = e_end + 1;
  endtask

  task automatic chk(input string nm, input int a, input int e);
    n_vec++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  function automatic int first_ev(input int from, input int to, input int b);
    for (int c = from; c <= to; c++) if (act[c][b] === 1'b1) return c;
    return -1;
  endfunction

  function automatic int cnt_ev(input int from, input int to, input int b);
    int n = 0;
    for (int c = from; c <= to; c++) if (act[c][b] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    int t0a, ea, t0b, eb, t0c, ec, sd, t0d, ed, t0e, ee, t0f, ef, rf;
    int t0g, eg, t0h, eh, t0i, ei, tr, er, ncyc, nb, wh;
    n_vec = 0; n_bad = 0; ur_cur = 1'b0; fill_pos = 0;
    for (int k = 0; k < MAXC; k++) begin
      vecs[k] = '0;
      vecs[k].n_rst = 1'b1;
    end
    vecs[0].n_rst = 1'b0;
    vecs[1].n_rst = 1'b0;

    build_packet(6, 2, 0, -1, 0, 1, 1'b0, t0a, ea);
    build_packet(fill_pos + 3, 0, 0, -1, 0, 1, 1'b0, t0b, eb);
    build_packet(fill_pos + 5, 3, 0, -1, 2, 1, 1'b0, t0c, ec);
    sd = fill_pos + 2;
    build_packet(sd, 1, 0, 3, 0, 1, 1'b0, t0d, ed);
    build_packet(fill_pos + 6, 2, 0, -1, 0, 1, 1'b0, t0e, ee);
    vecs[t0e + 70].start = 1'b1;
    vecs[t0e + 70].bc = 7'd5;
    build_packet(fill_pos + 3, 3, 0, -1, 0, 1, 1'b0, t0f, ef);
    rf = t0f + 100;
    vecs[rf].n_rst = 1'b0;
    for (int c = rf + 1; c <= ef; c++) begin
      vecs[c] = '0;
      vecs[c].n_rst = 1'b1;
    end
    fill_pos = rf + 1;
    ur_cur = 1'b0;
    build_packet(fill_pos + 2, 1, 0, -1, 0, 1, 1'b0, t0g, eg);
    build_packet(fill_pos + 3, 1, 0, -1, 0, 15, 1'b0, t0h, eh);
    build_packet(fill_pos + 3, 64, 0, -1, 0, 2, 1'b0, t0i, ei);
    while (fill_pos < 26000) begin
      nb = int'($urandom_range(0, 8));
      wh = (nb > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, nb)) : 0;
      build_packet(fill_pos + int'($urandom_range(1, 6)), nb,
                   int'($urandom_range(0, 20)), -1, wh,
                   int'($urandom_range(0, 15)), 1'b1, tr, er);
    end
    idle_until(fill_pos + 10);
    ncyc = fill_pos;

    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      n_rst       = vecs[c].n_rst;
      start       = vecs[c].start;
      byte_count  = vecs[c].bc;
      stuff_stall = vecs[c].stall;
      byte_valid  = vecs[c].valid;
      @(negedge clk);
      act[c] = {underrun_err, busy, tx_done, eop_active,
                shift_strobe, load_byte, load_sync, byte_req};
      n_vec++;
      if (act[c] !== vecs[c].exp) begin
        n_bad++;
        $display("FAIL cycle %0d outputs got %b expected %b (ur,busy,done,eop,ss,lb,ls,req)",
                 c, act[c], vecs[c].exp);
      end
    end

    chk("reset outputs", int'(act[1]), 0);
    chk("A load_sync latency", first_ev(t0a - 1, ea, B_LS) - (t0a - 1), 1);
    chk("A byte_req offset", first_ev(t0a, ea, B_REQ) - t0a, 48);
    chk("A byte_req count", cnt_ev(t0a, ea, B_REQ), 2);
    chk("A load_byte 1 offset", first_ev(t0a, ea, B_LB) - t0a, 64);
    chk("A load_byte 2 offset", first_ev(t0a + 65, ea, B_LB) - t0a, 128);
    chk("A eop cycles", cnt_ev(t0a, ea, B_EOP), 24);
    chk("A tx_done count", cnt_ev(t0a, ea + 3, B_DONE), 1);
    chk("A underrun", cnt_ev(t0a, ea, B_UR), 0);
    chk("B byte_req count", cnt_ev(t0b - 1, eb, B_REQ), 0);
    chk("B load_byte count", cnt_ev(t0b, eb, B_LB), 0);
    chk("B eop start", first_ev(t0b, eb, B_EOP) - t0b, 64);
    chk("B tx_done", first_ev(t0b, eb, B_DONE) - t0b, 88);
    chk("C underrun set", first_ev(t0c, ec, B_UR) - t0c, 128);
    chk("C abort cycle", int'(act[t0c + 128]), 8'hC0);
    chk("C eop start", first_ev(t0c, ec, B_EOP) - t0c, 129);
    chk("C tx_done", first_ev(t0c, ec, B_DONE) - t0c, 153);
    chk("C sticky at next start", int'(act[sd][B_UR]), 1);
    chk("C cleared after start", int'(act[sd + 1][B_UR]), 0);
    chk("D stalled byte_req", first_ev(t0d, ed, B_REQ) - t0d, 56);
    chk("D stalled load_byte", first_ev(t0d, ed, B_LB) - t0d, 72);
    chk("E load_sync count", cnt_ev(t0e - 1, ee, B_LS), 1);
    chk("E tx_done", first_ev(t0e, ee, B_DONE) - t0e, 216);
    chk("F reset mid data", int'(act[rf + 1]), 0);
    chk("F no eop", cnt_ev(rf + 1, t0g - 1, B_EOP), 0);
    chk("G tx_done", first_ev(t0g, eg, B_DONE) - t0g, 152);
    chk("H valid on boundary", first_ev(t0h, eh, B_LB) - t0h, 64);
    chk("H underrun", cnt_ev(t0h, eh, B_UR), 0);
    chk("I load_byte count", cnt_ev(t0i, ei, B_LB), 64);
    chk("I tx_done", first_ev(t0i, ei, B_DONE) - t0i, 4184);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
